vram_arbiter: RTL and testbench

//  Shares one single-port synchronous video RAM between two requesters. Video scanout

---
 rtl/vram_pkg.sv | 28 ++
 rtl/vram_tag_pipe.sv | 36 +++
 rtl/vram_arbiter.sv | 125 ++++++++++++
 tb/tb_vram_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: return-path tags and per-cycle grant.
package vram_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VID  = 2'd1,
        TAG_CPU  = 2'd2
    } vram_tag_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_CPU  = 2'd2
    } vram_grant_t;

    // Only reads need a return slot; CPU writes and idle cycles travel as TAG_NONE.
    function automatic vram_tag_t read_tag(input vram_grant_t grant, input logic we);
        vram_tag_t tag;
        tag = TAG_NONE;
        case (grant)
            GNT_VID: tag = TAG_VID;
            GNT_CPU: tag = we ? TAG_NONE : TAG_CPU;
            default: tag = TAG_NONE;
        endcase
        return tag;
    endfunction

endpackage

// File: rtl/vram_tag_pipe.sv
// Fixed-depth shift register of read tags; tag_out lines up with the VRAM read data.
module vram_tag_pipe
    import vram_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  vram_tag_t tag_in,
    output vram_tag_t tag_out
);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            vram_tag_t tag_reg;
            vram_tag_t tag_next;

            if (gi == 0) begin : g_head
                assign tag_next = tag_in;
            end else begin : g_body
                assign tag_next = g_stage[gi-1].tag_reg;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    tag_reg <= TAG_NONE;
                end else begin
                    tag_reg <= tag_next;
                end
            end
        end
    endgenerate

    assign tag_out = g_stage[DEPTH-1].tag_reg;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM sharing between video scanout (absolute priority) and a CPU
// valid/ready port. Registered memory command stage, tagged read return path.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1,
    parameter int VBLANK_ONLY  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vblank,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    vram_grant_t       grant;
    logic              cpu_window;
    logic              mem_en_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;
    vram_tag_t         issue_tag_reg;
    vram_tag_t         ret_tag;
    logic              vid_rvalid_reg;
    logic              cpu_rvalid_reg;
    logic [DATA_W-1:0] vid_rdata_reg;
    logic [DATA_W-1:0] cpu_rdata_reg;

    // Ready is independent of cpu_valid so the CPU side can never form a comb loop.
    assign cpu_window = (VBLANK_ONLY == 0) || vblank;
    assign cpu_ready  = !rst && !vid_req && cpu_window;

    always_comb begin
        grant = GNT_NONE;
        if (vid_req) begin
            grant = GNT_VID;
        end else if (cpu_valid && cpu_ready) begin
            grant = GNT_CPU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en_reg    <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            issue_tag_reg <= TAG_NONE;
        end else begin
            issue_tag_reg <= read_tag(grant, cpu_we);
            case (grant)
                GNT_VID: begin
                    mem_en_reg   <= 1'b1;
                    mem_we_reg   <= 1'b0;
                    mem_addr_reg <= vid_addr;
                end
                GNT_CPU: begin
                    mem_en_reg    <= 1'b1;
                    mem_we_reg    <= cpu_we;
                    mem_addr_reg  <= cpu_addr;
                    mem_wdata_reg <= cpu_wdata;
                end
                default: begin
                    mem_en_reg <= 1'b0;
                    mem_we_reg <= 1'b0;
                end
            endcase
        end
    end

    // The tag enters the pipe together with the issued command, so after
    // READ_LATENCY stages it sits beside the matching mem_rdata.
    vram_tag_pipe #(
        .DEPTH(READ_LATENCY)
    ) u_tag_pipe (
        .clk    (clk),
        .rst    (rst),
        .tag_in (issue_tag_reg),
        .tag_out(ret_tag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vid_rvalid_reg <= 1'b0;
            cpu_rvalid_reg <= 1'b0;
            vid_rdata_reg  <= '0;
            cpu_rdata_reg  <= '0;
        end else begin
            vid_rvalid_reg <= (ret_tag == TAG_VID);
            cpu_rvalid_reg <= (ret_tag == TAG_CPU);
            if (ret_tag == TAG_VID) begin
                vid_rdata_reg <= mem_rdata;
            end
            if (ret_tag == TAG_CPU) begin
                cpu_rdata_reg <= mem_rdata;
            end
        end
    end

    assign mem_en     = mem_en_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign vid_rvalid = vid_rvalid_reg;
    assign vid_rdata  = vid_rdata_reg;
    assign cpu_rvalid = cpu_rvalid_reg;
    assign cpu_rdata  = cpu_rdata_reg;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: two instances (RL=1 any-cycle CPU, RL=3 vblank-only CPU),
// each with its own VRAM model, reference shadow memory and per-port expectation queues.
module tb_vram_arbiter;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit done [2];

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return 8'(a[7:0] * 8'd7 + 8'd3) ^ a[15:8];
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int RL  = (gi == 0) ? 1 : 3;
        localparam int VBO = (gi == 0) ? 0 : 1;

        logic        rst, vblank, vid_req, cpu_valid, cpu_we;
        logic        cpu_ready, vid_rvalid, cpu_rvalid, mem_en, mem_we;
        logic [15:0] vid_addr, cpu_addr, mem_addr;
        logic [7:0]  cpu_wdata, vid_rdata, cpu_rdata, mem_wdata, mem_rdata;

        vram_arbiter #(
            .ADDR_W      (16),
            .DATA_W      (8),
            .READ_LATENCY(RL),
            .VBLANK_ONLY (VBO)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .vblank    (vblank),
            .vid_req   (vid_req),
            .vid_addr  (vid_addr),
            .vid_rvalid(vid_rvalid),
            .vid_rdata (vid_rdata),
            .cpu_valid (cpu_valid),
            .cpu_ready (cpu_ready),
            .cpu_we    (cpu_we),
            .cpu_addr  (cpu_addr),
            .cpu_wdata (cpu_wdata),
            .cpu_rvalid(cpu_rvalid),
            .cpu_rdata (cpu_rdata),
            .mem_en    (mem_en),
            .mem_we    (mem_we),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata)
        );

        // External VRAM: synchronous single port, RL-cycle read pipe, not cleared by reset.
        logic [7:0] ram [65536];
        bit         ram_wr [65536];
        logic [7:0] rd_pipe [RL];

        always @(posedge clk) begin
            if (mem_en && mem_we) begin
                ram[mem_addr]    <= mem_wdata;
                ram_wr[mem_addr] <= 1'b1;
            end
            rd_pipe[0] <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
            for (int k = 1; k < RL; k++) rd_pipe[k] <= rd_pipe[k-1];
        end
        assign mem_rdata = rd_pipe[RL-1];

        // Reference model state
        bit [7:0]  shadow [65536];
        bit        shadow_wr [65536];
        exp_t      vid_q [$];
        exp_t      cpu_q [$];
        bit        exp_en, exp_we, pend;
        bit [15:0] exp_addr;
        bit [7:0]  exp_wdata;

        function automatic string nm(input string s);
            return $sformatf("i%0d %s", gi, s);
        endfunction

        function automatic logic [7:0] model_rd(input logic [15:0] a);
            return shadow_wr[a] ? shadow[a] : init_val(a);
        endfunction

        // One clock of stimulus; the model decides the grant from the arbitration rules.
        task automatic step(input bit r, input bit vr, input bit vb, input bit cv, input bit cw,
                            input logic [15:0] va, input logic [15:0] ca, input logic [7:0] cd);
            bit rdy, cgo;
            rst = r; vid_req = vr; vid_addr = va; vblank = vb;
            cpu_valid = cv; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
            @(negedge clk);
            check(nm("mem_en"), mem_en, exp_en);
            check(nm("mem_we"), mem_we, exp_we);
            if (exp_en) check(nm("mem_addr"), mem_addr, exp_addr);
            if (exp_we) check(nm("mem_wdata"), mem_wdata, exp_wdata);
            rdy = !r && !vr && (VBO == 0 || vb);
            check(nm("cpu_ready"), cpu_ready, rdy);
            cgo = cv && rdy;
            exp_en = 1'b0;
            exp_we = 1'b0;
            if (r) begin
                while (vid_q.size() > 0 && vid_q[$].due > cyc) void'(vid_q.pop_back());
                while (cpu_q.size() > 0 && cpu_q[$].due > cyc) void'(cpu_q.pop_back());
            end else if (vr) begin
                vid_q.push_back('{model_rd(va), cyc + RL + 2});
                exp_en = 1'b1;
                exp_addr = va;
            end else if (cgo) begin
                exp_en = 1'b1;
                exp_we = cw;
                exp_addr = ca;
                if (cw) begin
                    shadow[ca] = cd;
                    shadow_wr[ca] = 1'b1;
                    exp_wdata = cd;
                end else begin
                    cpu_q.push_back('{model_rd(ca), cyc + RL + 2});
                end
            end
            pend = cv && !cgo;
            @(posedge clk);
            #1;
        endtask

        // Monitor: every cycle the model says whether a return is due and what it carries.
        bit         rst_d;
        bit         want_v, want_c;
        exp_t       ev, ec;
        logic [7:0] hold_vid, hold_cpu;

        always @(posedge clk) rst_d <= rst;

        always @(negedge clk) begin
            if (rst_d) begin
                hold_vid = '0;
                hold_cpu = '0;
            end
            want_v = vid_q.size() > 0 && vid_q[0].due == cyc;
            check(nm("vid_rvalid"), vid_rvalid, want_v);
            if (want_v) begin
                ev = vid_q.pop_front();
                check(nm("vid_rdata"), vid_rdata, ev.data);
                hold_vid = ev.data;
            end else begin
                check(nm("vid_rdata hold"), vid_rdata, hold_vid);
            end
            want_c = cpu_q.size() > 0 && cpu_q[0].due == cyc;
            check(nm("cpu_rvalid"), cpu_rvalid, want_c);
            if (want_c) begin
                ec = cpu_q.pop_front();
                check(nm("cpu_rdata"), cpu_rdata, ec.data);
                hold_cpu = ec.data;
            end else begin
                check(nm("cpu_rdata hold"), cpu_rdata, hold_cpu);
            end
        end

        initial begin
            bit          cv, cw;
            logic [15:0] ca;
            logic [7:0]  cd;
            exp_en = 1'b0; exp_we = 1'b0; pend = 1'b0;
            cv = 1'b0; cw = 1'b0; ca = '0; cd = '0;
            // reset held with both requesters active
            repeat (3) step(1, 1, 0, 1, 0, 16'h0010, 16'h0020, 8'h3C);
            // video read of a seeded word
            step(0, 0, 1, 1, 1, 16'h0000, 16'h0010, 8'hA5);
            step(0, 1, 1, 0, 0, 16'h0010, 16'h0000, 8'h00);
            repeat (4) step(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 8'h00);
            // contention: CPU write blocked while video requests
            repeat (4) step(0, 1, 1, 1, 1, 16'h8003, 16'h0020, 8'h3C);
            step(0, 0, 1, 1, 1, 16'h0000, 16'h0020, 8'h3C);
            step(0, 1, 1, 0, 0, 16'h0020, 16'h0000, 8'h00);
            // interleaved vid / cpu / vid reads
            step(0, 0, 1, 1, 1, 16'h0000, 16'h0001, 8'h11);
            step(0, 0, 1, 1, 1, 16'h0000, 16'h0002, 8'h22);
            step(0, 0, 1, 1, 1, 16'h0000, 16'h0003, 8'h33);
            step(0, 1, 1, 0, 0, 16'h0001, 16'h0000, 8'h00);
            step(0, 0, 1, 1, 0, 16'h0000, 16'h0002, 8'h00);
            step(0, 1, 1, 0, 0, 16'h0003, 16'h0000, 8'h00);
            repeat (6) step(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 8'h00);
            // vblank gating
            step(0, 0, 0, 1, 0, 16'h0000, 16'h0055, 8'h00);
            step(0, 0, 1, 1, 0, 16'h0000, 16'h0055, 8'h00);
            // reset one clock after a video read issue
            step(0, 1, 1, 0, 0, 16'hC00A, 16'h0000, 8'h00);
            step(1, 0, 1, 0, 0, 16'h0000, 16'h0000, 8'h00);
            repeat (6) step(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 8'h00);
            // randomized traffic with occasional resets
            for (int n = 0; n < 2000; n++) begin
                if (!pend) begin
                    cv = ($urandom_range(0, 2) != 0);
                    cw = 1'($urandom_range(0, 1));
                    ca = 16'($urandom) & 16'hC00F;
                    cd = 8'($urandom);
                end
                step($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3) != 0, cv, cw, 16'($urandom) & 16'hC00F, ca, cd);
            end
            repeat (8) step(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 8'h00);
            check(nm("vid queue drained"), vid_q.size(), 0);
            check(nm("cpu queue drained"), cpu_q.size(), 0);
            done[gi] = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 20000 && !(done[0] && done[1]); t++) @(posedge clk);
        check("bench completed", (done[0] && done[1]) ? 1 : 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
